// File: rtl/sequence_controller.sv
// -----------------------------------------------------------------------------
// sequence_controller
//
// Control sequencer for a minimal 8-opcode accumulator CPU. A free-running
// 3-bit phase counter steps through the eight phases of every instruction
// (fetch, decode, operand fetch, execute/store). The current phase, the opcode
// and the ALU zero flag are decoded into the datapath/memory control strobes.
//
// Ports
//   clk            in   system clock, phase advances on the rising edge
//   reset          in   asynchronous, active-low; 0 forces phase 0
//   zero           in   accumulator-is-zero flag from the ALU
//   opcode[2:0]    in   opcode of the current instruction
//   current_state  out  current phase, 0..7
//   mem_rd         out  memory read enable
//   load_ir        out  load instruction register
//   halt           out  halt indication (the counter keeps running)
//   inc_pc         out  increment program counter
//   load_ac        out  load accumulator
//   load_pc        out  load program counter
//   mem_rw         out  memory write enable (1 = write)
// -----------------------------------------------------------------------------
module sequence_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       zero,
    input  logic [2:0] opcode,
    output logic [2:0] current_state,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_rw
);

    typedef enum logic [2:0] {
        ST_INST_ADDR  = 3'd0,
        ST_INST_FETCH = 3'd1,
        ST_INST_LOAD  = 3'd2,
        ST_IDLE       = 3'd3,
        ST_OP_ADDR    = 3'd4,
        ST_OP_FETCH   = 3'd5,
        ST_ALU_OP     = 3'd6,
        ST_STORE      = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t r_state;
    state_t w_next_state;
    logic   w_aluop;

    // Opcodes that read an operand from memory and write the accumulator.
    assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INST_ADDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: unconditional step, 3-bit wrap takes 7 back to 0.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = state_t'(r_state + 3'd1);
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a strobe unassigned, which would infer a latch.
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_rw  = 1'b0;

        unique case (r_state)
            ST_INST_ADDR: begin
            end
            ST_INST_FETCH: begin
                mem_rd = 1'b1;
            end
            ST_INST_LOAD, ST_IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            ST_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            ST_OP_FETCH: begin
                mem_rd = w_aluop;
            end
            ST_ALU_OP: begin
                mem_rd  = w_aluop;
                // SKZ skips the next instruction by a second PC increment.
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_pc = (opcode == OP_JMP);
            end
            ST_STORE: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                inc_pc  = (opcode == OP_JMP);
                load_pc = (opcode == OP_JMP);
                mem_rw  = (opcode == OP_STO);
            end
            default: begin
            end
        endcase
    end

    assign current_state = r_state;

endmodule

// File: tb/tb_sequence_controller.sv
// -----------------------------------------------------------------------------
// tb_sequence_controller
//
// Self-checking bench for sequence_controller. The reference model keeps an
// integer count of counted rising edges since reset and derives the phase as
// count mod 8; the strobes are computed from the per-phase rules as plain
// boolean expressions over phase number, opcode and zero.
// -----------------------------------------------------------------------------
module tb_sequence_controller;

    logic       clk;
    logic       reset;
    logic       zero;
    logic [2:0] opcode;
    logic [2:0] current_state;
    logic       mem_rd;
    logic       load_ir;
    logic       halt;
    logic       inc_pc;
    logic       load_ac;
    logic       load_pc;
    logic       mem_rw;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cyc    = 0;   // counted rising edges since the last reset

    sequence_controller dut (
        .clk           (clk),
        .reset         (reset),
        .zero          (zero),
        .opcode        (opcode),
        .current_state (current_state),
        .mem_rd        (mem_rd),
        .load_ir       (load_ir),
        .halt          (halt),
        .inc_pc        (inc_pc),
        .load_ac       (load_ac),
        .load_pc       (load_pc),
        .mem_rw        (mem_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state[2:0], mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_rw}
    function automatic logic [9:0] model(int cyc, logic [2:0] op, logic z, logic rst);
        int   s;
        logic aluop;
        logic e_rd, e_ir, e_halt, e_inc, e_ac, e_pc, e_rw;
        s     = rst ? (cyc % 8) : 0;
        aluop = (op >= 3'd2) && (op <= 3'd5);
        e_rd   = (s >= 1 && s <= 3) || (s >= 5 && aluop);
        e_ir   = (s == 2) || (s == 3);
        e_halt = (s == 4) && (op == 3'd0);
        e_inc  = (s == 4) || (s == 6 && op == 3'd1 && z) || (s == 7 && op == 3'd7);
        e_ac   = (s == 7) && aluop;
        e_pc   = (s == 6 || s == 7) && (op == 3'd7);
        e_rw   = (s == 7) && (op == 3'd6);
        return {3'(s), e_rd, e_ir, e_halt, e_inc, e_ac, e_pc, e_rw};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                     tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
        end
    endtask

    task automatic sample(input string tag);
        #1;
        check(tag, {current_state, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_rw},
              model(m_cyc, opcode, zero, reset));
    endtask

    // Advance one clock; the model counts the edge only if reset was released.
    task automatic next_cycle();
        @(posedge clk);
        if (reset) m_cyc++;
        @(negedge clk);
    endtask

    // Force phase 0 with a short asynchronous reset pulse inside the low phase.
    task automatic align();
        @(negedge clk);
        #2 reset = 1'b0;
        m_cyc = 0;
        #1 reset = 1'b1;
    endtask

    task automatic sweep(input logic [2:0] op, input logic z, input string name);
        align();
        opcode = op;
        zero   = z;
        for (int i = 0; i < 9; i++) begin
            sample($sformatf("%s_ph%0d", name, i % 8));
            if (op == 3'd1 && (m_cyc % 8) == 6) begin
                zero = ~z;
                sample($sformatf("%s_zero_toggle", name));
                zero = z;
                sample($sformatf("%s_zero_restore", name));
            end
            next_cycle();
        end
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;

        // Reset held: phase 0, strobes low, whatever opcode/zero do.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            sample("rst_hold");
        end

        // Directed phase sweeps for the headline opcodes.
        sweep(3'd0, 1'b0, "hlt");
        sweep(3'd2, 1'b0, "add");
        sweep(3'd1, 1'b1, "skz_z1");
        sweep(3'd1, 1'b0, "skz_z0");
        sweep(3'd7, 1'b0, "jmp");
        sweep(3'd6, 1'b0, "sto");

        // Asynchronous reset in phase 5 takes effect with no clock edge.
        align();
        opcode = 3'd2;
        zero   = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        sample("pre_async_ph5");
        reset = 1'b0;
        m_cyc = 0;
        sample("async_rst_ph5");
        #1 reset = 1'b1;
        sample("async_rst_release");
        next_cycle();
        sample("resume_ph1");

        // Randomized run with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                #1 reset = 1'b0;
                m_cyc = 0;
                sample("rand_rst");
                reset = 1'b1;
            end
            sample("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Control sequencer for a minimal 8-opcode accumulator CPU.
- Free-running 3-bit state counter steps through eight phases per instruction: fetch, decode, operand fetch, execute/store.
- Decodes the current state, the instruction opcode and the ALU zero flag into the memory, IR, PC and accumulator control strobes.
- Sits between the instruction register/ALU and the datapath/memory.

Parameters:
- None. Widths are fixed: 3-bit state, 3-bit opcode.

Ports:
- clk  input  1  system clock; state advances on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the state to 0.
- zero  input  1  accumulator-is-zero flag from the ALU.
- opcode  input  3  opcode of the current instruction.
- current_state  output  3  current phase, 0..7.
- mem_rd  output  1  memory read enable.
- load_ir  output  1  load instruction register.
- halt  output  1  halt indication.
- inc_pc  output  1  increment program counter.
- load_ac  output  1  load accumulator.
- load_pc  output  1  load program counter.
- mem_rw  output  1  memory write enable (1 = write).

Behaviour:
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- ALUOP = (opcode is ADD, AND, XOR or LDA).
- States: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- State register:
  - reset=0 sets it to 0 immediately, independent of clk.
  - With reset=1, each rising clk edge increments it by 1, wrapping 7 -> 0.
  - No other transitions.
- current_state is the state register itself.
- Outputs are combinational from state, opcode and zero. No registered outputs; zero latency from input change.
- Any output not listed for a state is 0:
  - state 0: all outputs 0.
  - state 1: mem_rd=1.
  - state 2: mem_rd=1, load_ir=1.
  - state 3: mem_rd=1, load_ir=1.
  - state 4: inc_pc=1; halt = (opcode==HLT).
  - state 5: mem_rd = ALUOP.
  - state 6: mem_rd = ALUOP; inc_pc = (opcode==SKZ && zero); load_pc = (opcode==JMP).
  - state 7: mem_rd = ALUOP; load_ac = ALUOP; inc_pc = (opcode==JMP); load_pc = (opcode==JMP); mem_rw = (opcode==STO).
- halt is only an indication. The counter keeps stepping while halt is asserted; downstream logic gates the clock or PC.
- Reset asserted mid-instruction: the state drops to 0 at once and all strobes deassert at once. Counting resumes from 0 at the first rising edge after reset returns to 1.
- Reset released together with a clock edge: that edge does not count. The first increment happens on the following edge.
- zero only affects inc_pc in state 6. opcode only matters in states 4-7.
- No X propagation with defined inputs: every output is driven in every state, with a default of 0.

Test Plan:
- Reset behaviour:
  - Hold reset=0 for several clocks -> current_state=0, all seven strobes 0.
  - Drop reset=0 asynchronously while state=5 -> state 0 with no clock edge required.
- Free run with opcode=000 (HLT), zero=0, reset=1:
  - current_state steps 0,1,...,7,0 on successive rising edges.
  - halt=1 only in state 4.
  - mem_rd=1 in states 1-3; load_ir=1 in states 2-3; inc_pc=1 only in state 4; all else 0.
- opcode=010 (ADD):
  - mem_rd=1 in states 1,2,3,5,6,7.
  - load_ac=1 only in state 7; halt=0 throughout; mem_rw=0.
- opcode=001 (SKZ):
  - zero=1 -> inc_pc=1 in states 4 and 6.
  - zero=0 -> inc_pc=1 in state 4 only.
  - Toggling zero while in state 6 changes inc_pc combinationally.
- opcode=111 (JMP) -> load_pc=1 in states 6 and 7; inc_pc=1 in states 4 and 7; mem_rd=0 in states 5-7.
- opcode=110 (STO) -> mem_rw=1 only in state 7; load_ac=0 and mem_rd=0 in states 5-7.
